byte_serial_mult: RTL and testbench
===================================

BYTE_SERIAL_MULT -- requirements
Module: byte_serial_mult

Interface
REQ-001 SHALL have parameters: OPERAND_W, default 64, operand width; BYTE_W, default 8, multiplier slice width; NUM_BYTES, default OPERAND_W/BYTE_W (8), slices per operation.
REQ-002 SHALL have ports (clock and reset first), as listed in REQ-003 to REQ-014.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 op_a  input  64  unsigned multiplicand.
REQ-008 op_b  input  64  unsigned multiplier.
REQ-009 multiplicand  output  64  to byte multiplier stage.
REQ-010 byte_multiplier  output  8  to byte multiplier stage.
REQ-011 small_product  input  72  from byte multiplier stage, combinational (multiplicand*byte_multiplier, same cycle).
REQ-012 out_valid  output  1  product available.
REQ-013 out_ready  input  1  downstream accepts product.
REQ-014 product  output  128  op_a*op_b, unsigned.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low.
REQ-017 in_valid&in_ready at edge N SHALL latch op_a, op_b, clear accumulator and byte index, enter CALC.
REQ-018 In CALC, multiplicand SHALL equal latched op_a and byte_multiplier SHALL equal latched op_b[8*idx +: 8], idx 0..7.
REQ-019 Each CALC edge SHALL add small_product << (8*idx) into a 128-bit accumulator, then increment idx.
REQ-020 Accumulation SHALL be unsigned, truncated to 128 bits; no overflow is possible for 64x64 operands.
REQ-021 After the edge with idx=7 (edge N+8) the FSM SHALL enter DONE; out_valid SHALL be 1 from that cycle; latency is 8 cycles handshake-to-out_valid.
REQ-022 No early termination: zero operands and zero bytes SHALL still take 8 CALC cycles.
REQ-023 In DONE, product and out_valid SHALL stay stable until out_valid&out_ready; that edge returns to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; back-to-back ops incur one IDLE cycle between acceptance of the product and the next in_ready.
REQ-025 Outside CALC, multiplicand and byte_multiplier SHALL be driven 0.
REQ-026 product SHALL be 0 except in DONE.

Reset
REQ-027 rst high SHALL immediately force IDLE, idx=0, accumulator=0, latched operands=0, out_valid=0, product=0, in_ready=0, multiplicand=0, byte_multiplier=0.
REQ-028 rst mid-CALC or in DONE SHALL abort the operation with no product emitted; the first edge after rst deasserts SHALL see in_ready=1.

Structure
REQ-029 Widths (OPERAND_W, BYTE_W, NUM_BYTES, SMALL_PROD_W=72, PRODUCT_W=128) and the FSM state enum SHALL live in the shared mult constants package.
REQ-030 No sub-module SHALL be instantiated; the byte multiplier stage stays outside and is connected in the parent.

Verification
REQ-031 Bench SHALL connect a golden combinational 64x8 byte multiplier model to multiplicand/byte_multiplier/small_product.
REQ-032 op_a=0x2, op_b=0x3, out_ready=1 -> out_valid exactly 8 cycles after handshake, product=0x6.
REQ-033 op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-034 op_a=0x0123_4567_89AB_CDEF, op_b=0, out_ready low 5 cycles in DONE -> product=0 held stable, out_valid held, in_ready=0, concurrent in_valid ignored.
REQ-035 rst pulsed while idx=4 -> out_valid never asserts for that op, in_ready=1 after release; next op 0x10*0x10 -> product=0x100.
REQ-036 Two back-to-back ops with in_valid and out_ready held high -> second handshake exactly 1 cycle after first product acceptance; both products match golden model; 1000 random pairs match golden model.

Source files
------------

// File: rtl/byte_serial_mult_pkg.sv
// Shared constants and FSM state encoding for the byte-serial multiplier.
package byte_serial_mult_pkg;

  // Default operand width in bits.
  localparam int MULT_OPERAND_W = 64;
  // Width of one multiplier slice handed to the byte multiplier stage.
  localparam int MULT_BYTE_W    = 8;
  // Number of slices needed to cover one operand.
  localparam int MULT_NUM_BYTES = MULT_OPERAND_W / MULT_BYTE_W;
  // Width of multiplicand * slice, as returned by the byte multiplier stage.
  localparam int SMALL_PROD_W   = MULT_OPERAND_W + MULT_BYTE_W;
  // Width of the full product.
  localparam int PRODUCT_W      = 2 * MULT_OPERAND_W;

  // Operation sequencing: accept operands, step through slices, hold result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage : byte_serial_mult_pkg

// File: rtl/byte_serial_mult.sv
// Byte-serial unsigned multiplier. One multiplier slice is processed per
// clock by an external combinational byte multiplier stage; the partial
// products are shifted into place and summed into a double-width
// accumulator. A full operation takes NUM_BYTES cycles from operand
// acceptance to out_valid.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds data stable while valid is high and
// ready is low; ready never depends on valid of the same interface.
module byte_serial_mult
  import byte_serial_mult_pkg::*;
#(
  parameter int OPERAND_W = MULT_OPERAND_W,
  parameter int BYTE_W    = MULT_BYTE_W,
  parameter int NUM_BYTES = OPERAND_W / BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPERAND_W-1:0]        op_a,
  input  logic [OPERAND_W-1:0]        op_b,
  output logic [OPERAND_W-1:0]        multiplicand,
  output logic [BYTE_W-1:0]           byte_multiplier,
  input  logic [OPERAND_W+BYTE_W-1:0] small_product,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*OPERAND_W-1:0]      product
);

  localparam int SP_W  = OPERAND_W + BYTE_W;
  localparam int PR_W  = 2 * OPERAND_W;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  mult_state_e            state_q;
  mult_state_e            state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [OPERAND_W-1:0]   a_q;
  logic [OPERAND_W-1:0]   b_q;
  logic [PR_W-1:0]        acc_q;
  logic [PR_W-1:0]        sp_ext;
  logic [PR_W-1:0]        addend;
  logic                   accept_in;
  logic                   calc_step;

  // Partial product zero-extended and moved to the weight of the current slice.
  always_comb begin
    sp_ext = {{(PR_W - SP_W){1'b0}}, small_product};
    addend = sp_ext << (int'(idx_q) * BYTE_W);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and all handshake/stage-facing outputs.
  always_comb begin
    state_d         = state_q;
    accept_in       = 1'b0;
    calc_step       = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    product         = '0;
    multiplicand    = '0;
    byte_multiplier = '0;
    case (state_q)
      ST_IDLE: begin
        // in_ready is gated by rst so it drops the moment reset asserts.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept_in = 1'b1;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_step       = 1'b1;
        multiplicand    = a_q;
        byte_multiplier = b_q[int'(idx_q) * BYTE_W +: BYTE_W];
        // Every slice is processed, even zero ones: latency is fixed.
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        product   = acc_q;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand latch, slice index and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else if (accept_in) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc_q <= '0;
      idx_q <= '0;
    end else if (calc_step) begin
      // Truncation to PR_W is exact: the true product always fits.
      acc_q <= acc_q + addend;
      idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule : byte_serial_mult

// File: tb/tb_byte_serial_mult.sv
// Directed and random checks for byte_serial_mult with a golden
// combinational byte multiplier stage attached.
module tb_byte_serial_mult;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   op_a;
  logic [63:0]   op_b;
  logic [63:0]   multiplicand;
  logic [7:0]    byte_multiplier;
  logic [71:0]   small_product;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  product;

  int n_cmp = 0;
  int n_err = 0;

  byte_serial_mult dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op_a            (op_a),
    .op_b            (op_b),
    .multiplicand    (multiplicand),
    .byte_multiplier (byte_multiplier),
    .small_product   (small_product),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .product         (product)
  );

  // Golden byte multiplier stage.
  assign small_product = {8'h00, multiplicand} * {64'h0, byte_multiplier};

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation; returns product and handshake-to-out_valid latency
  // (-1 if no handshake or no result within budget). Consumes the edge after
  // out_valid so that with out_ready high the DUT is back in IDLE on return.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [127:0] p, output int lat);
    int   guard;
    logic hs;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    guard    = 0;
    do begin
      hs = in_ready;
      step();
      guard++;
    end while (!hs && guard < 50);
    in_valid = 1'b0;
    lat      = 0;
    p        = '0;
    if (!hs) begin
      lat = -1;
    end else begin
      while (!out_valid && lat < 50) begin
        step();
        lat++;
      end
      if (!out_valid) lat = -1;
      p = product;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #3;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (product !== 128'h0) begin n_err++; $display("FAIL reset_product: got %h want 0", product); end
    n_cmp++; if (multiplicand !== 64'h0) begin n_err++; $display("FAIL reset_multiplicand: got %h want 0", multiplicand); end
    n_cmp++; if (byte_multiplier !== 8'h0) begin n_err++; $display("FAIL reset_byte_mult: got %h want 0", byte_multiplier); end
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_small();
    int lat;
    out_ready = 1'b1;
    op_a = 64'h2; op_b = 64'h3; in_valid = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL small_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (multiplicand !== 64'h2) begin n_err++; $display("FAIL small_multiplicand: got %h want 2", multiplicand); end
    n_cmp++; if (byte_multiplier !== 8'h3) begin n_err++; $display("FAIL small_byte0: got %h want 3", byte_multiplier); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL small_busy_in_ready: got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL small_latency: got %0d want 8", lat); end
    n_cmp++; if (product !== 128'h6) begin n_err++; $display("FAIL small_product: got %h want 6", product); end
    n_cmp++; if (multiplicand !== 64'h0) begin n_err++; $display("FAIL small_done_multiplicand: got %h want 0", multiplicand); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL small_after_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (product !== 128'h0) begin n_err++; $display("FAIL small_after_product: got %h want 0", product); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL small_after_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_max();
    logic [127:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, p, lat);
    n_cmp++; if (p !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin n_err++; $display("FAIL max_product: got %h want fffffffffffffffe0000000000000001", p); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL max_latency: got %0d want 8", lat); end
  endtask

  task automatic test_stall();
    logic [127:0] p;
    int lat;
    logic seen;
    out_ready = 1'b0;
    run_op(64'h0123_4567_89AB_CDEF, 64'h0, p, lat);
    n_cmp++; if (p !== 128'h0) begin n_err++; $display("FAIL stall_product: got %h want 0", p); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL stall_latency: got %0d want 8", lat); end
    // Offer a new operand pair while the result is held.
    op_a = 64'h5; op_b = 64'h7; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (product !== 128'h0) begin n_err++; $display("FAIL stall_hold_product[%0d]: got %h want 0", i, product); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stall_ignored_in_valid: got out_valid=1 want none"); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] p;
    int lat;
    logic seen;
    out_ready = 1'b1;
    op_a = 64'h1234; op_b = 64'h0506_0708_090A_0B0C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    n_cmp++; if (byte_multiplier !== 8'h08) begin n_err++; $display("FAIL midrst_byte4: got %h want 08", byte_multiplier); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (multiplicand !== 64'h0) begin n_err++; $display("FAIL midrst_multiplicand: got %h want 0", multiplicand); end
    n_cmp++; if (byte_multiplier !== 8'h0) begin n_err++; $display("FAIL midrst_byte_mult: got %h want 0", byte_multiplier); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_product: got out_valid=1 want none"); end
    run_op(64'h10, 64'h10, p, lat);
    n_cmp++; if (p !== 128'h100) begin n_err++; $display("FAIL midrst_next_product: got %h want 100", p); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    int hs_cyc[2];
    int acc_cyc[2];
    logic [127:0] prod[2];
    int n_hs, n_acc, c;
    n_hs = 0; n_acc = 0; c = 0;
    out_ready = 1'b1;
    op_a = 64'h0000_0001_0000_0001; op_b = 64'hFFFF; in_valid = 1'b1;
    while (n_acc < 2 && c < 60) begin
      if (in_valid && in_ready && n_hs < 2) begin
        hs_cyc[n_hs] = c;
        n_hs++;
      end
      if (out_valid && out_ready) begin
        acc_cyc[n_acc] = c;
        prod[n_acc] = product;
        n_acc++;
      end
      step();
      c++;
      if (n_hs == 1) begin
        op_a = 64'h8000_0000_0000_0000; op_b = 64'h2;
      end
      if (n_hs == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++; if (n_acc !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", n_acc); end
    if (n_acc == 2 && n_hs == 2) begin
      n_cmp++; if (prod[0] !== 128'hFFFF_0000_FFFF) begin n_err++; $display("FAIL b2b_product0: got %h want ffff0000ffff", prod[0]); end
      n_cmp++; if (prod[1] !== 128'h1_0000_0000_0000_0000) begin n_err++; $display("FAIL b2b_product1: got %h want 10000000000000000", prod[1]); end
      n_cmp++; if (hs_cyc[1] !== acc_cyc[0] + 1) begin n_err++; $display("FAIL b2b_gap: got hs at %0d want %0d", hs_cyc[1], acc_cyc[0] + 1); end
      n_cmp++; if (acc_cyc[0] !== hs_cyc[0] + 9) begin n_err++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc[0], hs_cyc[0] + 9); end
    end
  endtask

  task automatic test_random();
    logic [63:0]  a, b;
    logic [127:0] p, exp;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 10 == 1) b = b & 64'hFF00_FF00_FF00_FF00;
      if (i % 10 == 2) a = 64'hFFFF_FFFF_FFFF_FFFF;
      exp = {64'h0, a} * {64'h0, b};
      run_op(a, b, p, lat);
      n_cmp++; if (p !== exp) begin n_err++; $display("FAIL rand_product[%0d]: a=%h b=%h got %h want %h", i, a, b, p, exp); end
      n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 8", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_max();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_byte_serial_mult
